// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel/line counters, sync decode and a short
// ce-gated delay line that keeps hsync/vsync/display_on_d aligned with registered RGB.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0,
    parameter int unsigned SYNC_DELAY  = 1     // legal range 0..3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       display_on_d,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_END = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_END = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // {hsync, vsync, display_on} as held by a delay stage out of reset
    localparam logic [2:0] PIPE_IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [7:0] frame_q, frame_d;
    logic       hsync_raw, vsync_raw;
    logic [2:0] raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (ce) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                if (vpos_q == V_LAST) begin
                    vpos_d  = '0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    vpos_d = vpos_q + 10'd1;
                end
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end
    end

    always_comb begin
        display_on = (hpos_q < H_DISP_END) && (vpos_q < V_DISP_END);
        hsync_raw  = ((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_raw  = ((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw        = {hsync_raw, vsync_raw, display_on};
    end

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign {hsync, vsync, display_on_d} = raw;
    end else begin : g_delay
        logic [2:0] pipe_q [SYNC_DELAY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                    pipe_q[i] <= PIPE_IDLE;
                end
            end else if (ce) begin
                pipe_q[0] <= raw;
                for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign {hsync, vsync, display_on_d} = pipe_q[SYNC_DELAY-1];
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_count = frame_q;
    assign line_start  = ce && (hpos_q == '0);
    assign frame_start = ce && (hpos_q == '0) && (vpos_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three full-size instances (delay 0/1/3) plus a tiny-raster
// instance with positive sync, all checked per cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int NDUT    = 4;
    localparam int S_FRAME = 120;  // 15 x 8 raster of the small instance

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic [7:0] frame;
        logic       disp;
        logic       disp_d;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int          id;
        int unsigned n;
        obs_t        e;
    } sb_t;

    typedef struct packed {
        int unsigned n;
        logic [9:0]  hpos;
        logic [9:0]  vpos;
        logic [6:0]  flags;  // disp, ls, fs, hs(d0), hs(d1), hs(d3), disp_d(d1)
    } vec_t;

    logic clk, rst_n, ce;
    logic [9:0] hp [NDUT];
    logic [9:0] vp [NDUT];
    logic [7:0] fc [NDUT];
    logic don [NDUT], dond [NDUT], hsy [NDUT], vsy [NDUT], ls [NDUT], fs [NDUT];

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned n = 0;   // ce edges since last reset release
    sb_t         sb [$];
    vec_t        tbl [$];

    vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(hp[0]), .vpos(vp[0]),
        .display_on(don[0]), .display_on_d(dond[0]), .hsync(hsy[0]), .vsync(vsy[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0])
    );
    vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(hp[1]), .vpos(vp[1]),
        .display_on(don[1]), .display_on_d(dond[1]), .hsync(hsy[1]), .vsync(vsy[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1])
    );
    vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(hp[2]), .vpos(vp[2]),
        .display_on(don[2]), .display_on_d(dond[2]), .hsync(hsy[2]), .vsync(vsy[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2])
    );
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(1'b1), .SYNC_DELAY(2)
    ) u_sm (
        .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(hp[3]), .vpos(vp[3]),
        .display_on(don[3]), .display_on_d(dond[3]), .hsync(hsy[3]), .vsync(vsy[3]),
        .line_start(ls[3]), .frame_start(fs[3]), .frame_count(fc[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after n ce edges, derived directly from raster arithmetic
    function automatic obs_t model(int unsigned nn, logic v, int unsigned hd, int unsigned hf,
                                   int unsigned hsw, int unsigned hb, int unsigned vd,
                                   int unsigned vf, int unsigned vsw, int unsigned vb,
                                   logic sa, int unsigned d);
        obs_t        o;
        int unsigned ht, vt, h, vv, hr, vr;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        h  = nn % ht;
        vv = (nn / ht) % vt;
        o.hpos  = 10'(h);
        o.vpos  = 10'(vv);
        o.frame = 8'((nn / (ht * vt)) % 256);
        o.disp  = (h < hd) && (vv < vd);
        o.ls    = v && (h == 0);
        o.fs    = v && (h == 0) && (vv == 0);
        if (nn >= d) begin
            hr       = (nn - d) % ht;
            vr       = ((nn - d) / ht) % vt;
            o.disp_d = (hr < hd) && (vr < vd);
            o.hs     = (hr >= hd + hf && hr < hd + hf + hsw) ? sa : ~sa;
            o.vs     = (vr >= vd + vf && vr < vd + vf + vsw) ? sa : ~sa;
        end else begin
            o.disp_d = 1'b0;
            o.hs     = ~sa;
            o.vs     = ~sa;
        end
        return o;
    endfunction

    function automatic obs_t exp_for(int id, int unsigned nn, logic v);
        case (id)
            0:       return model(nn, v, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 0);
            1:       return model(nn, v, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1);
            2:       return model(nn, v, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 3);
            default: return model(nn, v, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 2);
        endcase
    endfunction

    function automatic obs_t got(int id);
        return {hp[id], vp[id], fc[id], don[id], dond[id], hsy[id], vsy[id], ls[id], fs[id]};
    endfunction

    function automatic vec_t mk(int unsigned nn, int unsigned h, int unsigned v, logic [6:0] f);
        vec_t t;
        t.n     = nn;
        t.hpos  = 10'(h);
        t.vpos  = 10'(v);
        t.flags = f;
        return t;
    endfunction

    task automatic check_obs(input int id, input int unsigned nn, input obs_t e);
        obs_t g;
        g = got(id);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL dut%0d n=%0d: got h=%0d v=%0d fc=%0d on=%b on_d=%b hs=%b vs=%b ls=%b fs=%b, want h=%0d v=%0d fc=%0d on=%b on_d=%b hs=%b vs=%b ls=%b fs=%b",
                     id, nn, g.hpos, g.vpos, g.frame, g.disp, g.disp_d, g.hs, g.vs, g.ls, g.fs,
                     e.hpos, e.vpos, e.frame, e.disp, e.disp_d, e.hs, e.vs, e.ls, e.fs);
        end
    endtask

    task automatic check_val(input string name, input int g, input int w);
        n_cmp++;
        if (g != w) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, g, w);
        end
    endtask

    // Push expectations for the current ce, then compare once outputs have settled
    task automatic score();
        sb_t it;
        for (int i = 0; i < NDUT; i++) sb.push_back('{i, n, exp_for(i, n, ce)});
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check_obs(it.id, it.n, it.e);
        end
    endtask

    task automatic step(input logic v);
        @(negedge clk);
        ce = v;
        score();
    endtask

    initial begin : main
        vec_t tv, gv;
        int   ti, hs_low, first_low, ls_cnt;

        tbl.push_back(mk(0,   0,   0, 7'b1111110));
        tbl.push_back(mk(1,   1,   0, 7'b1001111));
        tbl.push_back(mk(639, 639, 0, 7'b1001111));
        tbl.push_back(mk(640, 640, 0, 7'b0001111));
        tbl.push_back(mk(641, 641, 0, 7'b0001110));
        tbl.push_back(mk(655, 655, 0, 7'b0001110));
        tbl.push_back(mk(656, 656, 0, 7'b0000110));
        tbl.push_back(mk(657, 657, 0, 7'b0000010));
        tbl.push_back(mk(658, 658, 0, 7'b0000010));
        tbl.push_back(mk(659, 659, 0, 7'b0000000));
        tbl.push_back(mk(751, 751, 0, 7'b0000000));
        tbl.push_back(mk(752, 752, 0, 7'b0001000));
        tbl.push_back(mk(753, 753, 0, 7'b0001100));
        tbl.push_back(mk(754, 754, 0, 7'b0001100));
        tbl.push_back(mk(755, 755, 0, 7'b0001110));
        tbl.push_back(mk(799, 799, 0, 7'b0001110));
        tbl.push_back(mk(800, 0,   1, 7'b1101110));
        tbl.push_back(mk(801, 1,   1, 7'b1001111));

        rst_n = 1'b0;
        ce    = 1'b0;
        step(1'b0);
        step(1'b1);
        step(1'b0);
        rst_n = 1'b1;

        // Continuous ce: first two lines, table checkpoints and hsync width on line 0
        ti        = 0;
        hs_low    = 0;
        first_low = -1;
        for (int k = 0; k < 1700; k++) begin
            step(1'b1);
            if (ti < tbl.size() && tbl[ti].n == n) begin
                tv = tbl[ti];
                gv = mk(n, {22'd0, hp[1]}, {22'd0, vp[1]},
                        {don[1], ls[1], fs[1], hsy[0], hsy[1], hsy[2], dond[1]});
                n_cmp++;
                if (gv !== tv) begin
                    n_bad++;
                    $display("FAIL tbl[%0d] n=%0d: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                             ti, n, gv.hpos, gv.vpos, gv.flags, tv.hpos, tv.vpos, tv.flags);
                end
                ti++;
            end
            if (n < 800 && hsy[1] == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(hp[1]);
            end
            n++;
        end
        check_val("tbl_entries_hit", ti, tbl.size());
        check_val("hsync_d1_width", hs_low, 96);
        check_val("hsync_d1_first_hpos", first_low, 657);

        // ce toggling: one line spans 1600 clocks
        hs_low = 0;
        ls_cnt = 0;
        for (int k = 0; k < 1600; k++) begin
            step((k % 2) == 0);
            if (ce && hsy[1] == 1'b0) hs_low++;
            if (ls[1]) ls_cnt++;
            if (ce) n++;
        end
        check_val("alt_hsync_width", hs_low, 96);
        check_val("alt_line_starts", ls_cnt, 1);

        // Asynchronous reset mid-frame
        while (n < 2700) begin
            step(1'b1);
            n++;
        end
        @(negedge clk);
        #1;
        check_val("pre_rst_hpos", int'(hp[1]), 300);
        check_val("pre_rst_vpos", int'(vp[1]), 3);
        #2;
        rst_n = 1'b0;
        n     = 0;
        score();
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        n     = 1;

        // 256 small frames: frame_count wraps back to 0
        while (n < 256 * S_FRAME + 5) begin
            step(1'b1);
            if (n == 256 * S_FRAME - 1) check_val("fc_before_wrap", int'(fc[3]), 255);
            if (n == 256 * S_FRAME)     check_val("fc_after_wrap", int'(fc[3]), 0);
            n++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for the 640x480@60 Hz TinyVGA path. Produces pixel coordinates, a display-active flag and sync pulses that feed the pixel/colour stages (logo renderers, bouncing-sprite logic), plus frame/line strobes and a frame counter for animation. Sync outputs carry a programmable pipeline delay so they stay aligned with downstream registered RGB.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted sync level (0 = negative polarity)
- SYNC_DELAY, 1, pipeline stages on hsync/vsync/display_on_d, legal 0..3
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ce  in  1  pixel clock enable; counters advance only when 1
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- display_on  out  1  hpos<H_DISPLAY && vpos<V_DISPLAY (undelayed)
- display_on_d  out  1  display_on delayed SYNC_DELAY ce-cycles
- hsync  out  1  horizontal sync, delayed SYNC_DELAY ce-cycles
- vsync  out  1  vertical sync, delayed SYNC_DELAY ce-cycles
- line_start  out  1  1 while hpos==0 and ce==1
- frame_start  out  1  1 while hpos==0, vpos==0 and ce==1
- frame_count  out  8  completed-frame counter, wraps 255->0

## Operation
- H_TOTAL = sum of H params (800), V_TOTAL = sum of V params (525).
- hpos increments on each clk edge with ce=1; at H_TOTAL-1 wraps to 0 and vpos increments; vpos at V_TOTAL-1 wraps to 0 simultaneously with hpos wrap.
- frame_count increments on the same edge where (hpos,vpos) go (H_TOTAL-1,V_TOTAL-1) -> (0,0).
- Raw hsync active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751]; raw vsync active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491]; active means output equals SYNC_ACTIVE.
- Delay line: SYNC_DELAY register stages on {hsync, vsync, display_on}, shifting only when ce=1. SYNC_DELAY=0: outputs are combinational decode of counters.
- line_start/frame_start/display_on are combinational from registered counters (gated by ce for strobes).
- ce=0: all registers hold; strobes low.

## Timing
- Reset (async assert, any time incl. mid-frame): hpos=0, vpos=0, frame_count=0, all delay stages hold inactive sync (~SYNC_ACTIVE) and display_on_d=0. Thus after reset hsync=vsync=~SYNC_ACTIVE, display_on=1, frame_start=ce.
- Release synchronous to clk; first count on first ce edge after rst_n high.
- Latency: hsync/vsync/display_on_d lag raw decode by exactly SYNC_DELAY ce-cycles; hpos/vpos/display_on zero latency.
- Period: one line = 800 ce-cycles, one frame = 420000 ce-cycles.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1; 10-bit width fixed, H_TOTAL,V_TOTAL <= 1024.

## Test plan
- Reset then ce=1 constantly: hpos counts 0..799, wraps to 0 with vpos 0->1; frame_start high only at (0,0); line_start high every 800 cycles.
- SYNC_DELAY=1, SYNC_ACTIVE=0: hsync low for exactly 96 cycles, first low cycle when hpos==657; vsync low for 1600 cycles starting at (1,490); display_on_d rises one cycle after display_on.
- Run 256 full frames: frame_count increments at each (799,524)->(0,0) edge, reads 0 again after the 256th wrap.
- ce toggling 1/0 alternately: hpos advances every 2 clks, line = 1600 clks; strobes high only on ce=1 cycles; sync widths 96 ce-cycles.
- Assert rst_n=0 at (hpos=300,vpos=200): immediately hpos=vpos=0, frame_count=0, hsync=vsync=1, display_on_d=0; resumes counting from 0 after release.
- SYNC_DELAY=0 and 3: hsync first active at hpos 656 and 659 respectively; reset values of delayed outputs remain inactive for first 3 ce-cycles with SYNC_DELAY=3.
